// File: rtl/cmp_run_monitor.sv
// cmp_run_monitor: watches the E/G/L result of a 4-bit magnitude comparator.
// Keeps saturating per-outcome counters, tracks the current run of identical
// outcomes, raises sticky GT/LT run alarms and a sticky not-one-hot error.
module cmp_run_monitor #(
  parameter int CNT_W  = 8,
  parameter int RUN_W  = 4,
  parameter int RUN_TH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             E,
  input  logic             G,
  input  logic             L,
  input  logic             clr,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [1:0]       run_type,
  output logic [RUN_W-1:0] run_len,
  output logic             gt_alarm,
  output logic             lt_alarm,
  output logic             err,
  output logic             out_valid
);

  // Run state encoding doubles as the run_type output code.
  localparam logic [1:0] RT_NONE = 2'b00;
  localparam logic [1:0] RT_EQ   = 2'b01;
  localparam logic [1:0] RT_GT   = 2'b10;
  localparam logic [1:0] RT_LT   = 2'b11;

  localparam logic [RUN_W-1:0] LEN_MAX = '1;
  localparam logic [RUN_W-1:0] LEN_TH  = RUN_W'(RUN_TH);

  // Counters as a packed array: index 0 = EQ, 1 = GT, 2 = LT.
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            run_type_q, run_type_d;
  logic [RUN_W-1:0]      run_len_q, run_len_d;
  logic                  gt_alarm_q, gt_alarm_d;
  logic                  lt_alarm_q, lt_alarm_d;
  logic                  err_q, err_d;
  logic                  out_valid_q, out_valid_d;

  logic       accept;
  logic       legal;
  logic [1:0] cls;
  logic [2:0] hit;

  // Classify the incoming sample; anything not exactly one-hot is illegal.
  always_comb begin
    cls = RT_NONE;
    unique case ({E, G, L})
      3'b100:  cls = RT_EQ;
      3'b010:  cls = RT_GT;
      3'b001:  cls = RT_LT;
      default: cls = RT_NONE;
    endcase
  end

  // clr wins over a simultaneous sample, which is then dropped.
  assign accept = in_valid & ~clr;
  assign legal  = (cls != RT_NONE);
  assign hit    = {L, G, E} & {3{accept & legal}};

  // One saturating counter per outcome.
  for (genvar i = 0; i < 3; i++) begin : g_cnt
    assign cnt_d[i] = clr                      ? '0 :
                      (hit[i] & ~&cnt_q[i])    ? cnt_q[i] + 1'b1 :
                                                 cnt_q[i];
  end

  // Run tracking, alarms and error flag; idle cycles hold everything.
  always_comb begin
    run_type_d  = run_type_q;
    run_len_d   = run_len_q;
    gt_alarm_d  = gt_alarm_q;
    lt_alarm_d  = lt_alarm_q;
    err_d       = err_q;
    out_valid_d = in_valid | clr;
    if (clr) begin
      run_type_d = RT_NONE;
      run_len_d  = '0;
      gt_alarm_d = 1'b0;
      lt_alarm_d = 1'b0;
      err_d      = 1'b0;
    end else if (accept) begin
      if (!legal) begin
        err_d      = 1'b1;
        run_type_d = RT_NONE;
        run_len_d  = '0;
      end else begin
        if (cls == run_type_q) begin
          run_len_d = (run_len_q == LEN_MAX) ? run_len_q : run_len_q + 1'b1;
        end else begin
          run_type_d = cls;
          run_len_d  = {{(RUN_W-1){1'b0}}, 1'b1};
        end
        // Threshold is below LEN_MAX or equal to it; a saturated run keeps
        // matching but the alarm is already set, so re-setting is harmless.
        if (run_len_d == LEN_TH) begin
          if (run_type_d == RT_GT) gt_alarm_d = 1'b1;
          if (run_type_d == RT_LT) lt_alarm_d = 1'b1;
        end
      end
    end
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      run_type_q  <= RT_NONE;
      run_len_q   <= '0;
      gt_alarm_q  <= 1'b0;
      lt_alarm_q  <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      run_type_q  <= run_type_d;
      run_len_q   <= run_len_d;
      gt_alarm_q  <= gt_alarm_d;
      lt_alarm_q  <= lt_alarm_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign eq_cnt    = cnt_q[0];
  assign gt_cnt    = cnt_q[1];
  assign lt_cnt    = cnt_q[2];
  assign run_type  = run_type_q;
  assign run_len   = run_len_q;
  assign gt_alarm  = gt_alarm_q;
  assign lt_alarm  = lt_alarm_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cmp_run_monitor.sv
// Randomized + directed bench for cmp_run_monitor against a behavioural model.
module tb_cmp_run_monitor;
  localparam int CNT_W  = 8;
  localparam int RUN_W  = 4;
  localparam int RUN_TH = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int RMAX   = (1 << RUN_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, E, G, L, clr;
  logic [CNT_W-1:0] eq_cnt, gt_cnt, lt_cnt;
  logic [1:0]       run_type;
  logic [RUN_W-1:0] run_len;
  logic             gt_alarm, lt_alarm, err, out_valid;

  int n_vec  = 0;
  int n_miss = 0;

  cmp_run_monitor #(.CNT_W(CNT_W), .RUN_W(RUN_W), .RUN_TH(RUN_TH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .E(E), .G(G), .L(L),
    .clr(clr), .eq_cnt(eq_cnt), .gt_cnt(gt_cnt), .lt_cnt(lt_cnt),
    .run_type(run_type), .run_len(run_len), .gt_alarm(gt_alarm),
    .lt_alarm(lt_alarm), .err(err), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference model: outcome counts, current run (0 none,1 eq,2 gt,3 lt).
  int m_cnt[3];
  int m_rt, m_rl;
  bit m_ga, m_la, m_err, m_ov;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_rt = 0; m_rl = 0; m_ga = 0; m_la = 0; m_err = 0; m_ov = 0;
  endtask

  task automatic model_step(input bit v, input bit e, input bit g, input bit l, input bit c);
    int cls;
    m_ov = v | c;
    if (c) begin
      model_reset();
      m_ov = 1;
    end else if (v) begin
      if (int'(e) + int'(g) + int'(l) == 1) begin
        cls = e ? 1 : (g ? 2 : 3);
        if (m_cnt[cls-1] < CMAX) m_cnt[cls-1]++;
        if (cls == m_rt) begin
          if (m_rl < RMAX) m_rl++;
        end else begin
          m_rt = cls; m_rl = 1;
        end
        if (m_rl == RUN_TH && m_rt == 2) m_ga = 1;
        if (m_rl == RUN_TH && m_rt == 3) m_la = 1;
      end else begin
        m_err = 1; m_rt = 0; m_rl = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("eq_cnt", 32'(eq_cnt), 32'(m_cnt[0]));
    chk("gt_cnt", 32'(gt_cnt), 32'(m_cnt[1]));
    chk("lt_cnt", 32'(lt_cnt), 32'(m_cnt[2]));
    chk("run_type", 32'(run_type), 32'(m_rt));
    chk("run_len", 32'(run_len), 32'(m_rl));
    chk("gt_alarm", 32'(gt_alarm), 32'(m_ga));
    chk("lt_alarm", 32'(lt_alarm), 32'(m_la));
    chk("err", 32'(err), 32'(m_err));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
  endtask

  task automatic step(input bit v, input bit e, input bit g, input bit l, input bit c);
    @(negedge clk);
    in_valid = v; E = e; G = g; L = l; clr = c;
    @(posedge clk);
    model_step(v, e, g, l, c);
    #1 check_all();
  endtask

  // Drive the comparator result a 4-bit A/B pair would produce.
  task automatic step_ab(input logic [3:0] a, input logic [3:0] b);
    step(1, a == b, a > b, a < b, 0);
  endtask

  initial begin
    int cls_prev;
    int r, cls;
    rst_n = 0; in_valid = 0; E = 0; G = 0; L = 0; clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst_n = 1;

    // idle after reset
    repeat (3) step(0, 0, 0, 0, 0);

    // four G samples reach the threshold on the 4th
    for (int i = 0; i < 4; i++) begin
      step_ab(4'b1101, 4'b1010);
      if (i == 2) chk("ga_after3", 32'(gt_alarm), 0);
    end
    chk("gt4_cnt", 32'(gt_cnt), 4);
    chk("gt4_rt", 32'(run_type), 2);
    chk("gt4_len", 32'(run_len), 4);
    chk("gt4_alarm", 32'(gt_alarm), 1);

    // G,G,E,G,G,G : run broken by E, no alarm
    step(0, 0, 0, 0, 1);
    step_ab(4'b1101, 4'b1010); step_ab(4'b1101, 4'b1010);
    step_ab(4'b0001, 4'b0001);
    repeat (3) step_ab(4'b1101, 4'b1010);
    chk("ggeggg_eq", 32'(eq_cnt), 1);
    chk("ggeggg_gt", 32'(gt_cnt), 5);
    chk("ggeggg_len", 32'(run_len), 3);
    chk("ggeggg_ga", 32'(gt_alarm), 0);

    // L,L,L, illegal 011, L
    step(0, 0, 0, 0, 1);
    repeat (3) step_ab(4'b1100, 4'b1110);
    step(1, 0, 1, 1, 0);
    step_ab(4'b1100, 4'b1110);
    chk("ill_err", 32'(err), 1);
    chk("ill_lt", 32'(lt_cnt), 4);
    chk("ill_len", 32'(run_len), 1);
    chk("ill_rt", 32'(run_type), 3);
    chk("ill_la", 32'(lt_alarm), 0);

    // clr with a simultaneous G sample
    step(1, 0, 1, 0, 1);
    chk("clr_gt", 32'(gt_cnt), 0);
    chk("clr_ov", 32'(out_valid), 1);
    chk("clr_err", 32'(err), 0);

    // 300 E samples saturate the counter and the run length
    for (int i = 0; i < 300; i++) step_ab(4'b0001, 4'b0001);
    chk("sat_eq", 32'(eq_cnt), 255);
    chk("sat_len", 32'(run_len), 15);
    chk("sat_ga", 32'(gt_alarm), 0);

    // async reset between edges
    @(posedge clk);
    #2 rst_n = 0; in_valid = 0;
    #1;
    chk("arst_eq", 32'(eq_cnt), 0);
    chk("arst_len", 32'(run_len), 0);
    chk("arst_ov", 32'(out_valid), 0);
    model_reset();
    @(negedge clk) rst_n = 1;
    step_ab(4'b0111, 4'b0111);
    chk("post_rst_len", 32'(run_len), 1);

    // randomized: sticky class to build runs, occasional illegal / clr / idle
    cls_prev = 1;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) step(($urandom & 1) != 0, 1, 0, 0, 1);
      else if (r < 22) step(0, $urandom & 1, $urandom & 1, $urandom & 1, 0);
      else if (r < 27) begin
        case ($urandom_range(0, 4))
          0: step(1, 0, 0, 0, 0);
          1: step(1, 1, 1, 0, 0);
          2: step(1, 1, 0, 1, 0);
          3: step(1, 0, 1, 1, 0);
          default: step(1, 1, 1, 1, 0);
        endcase
      end else begin
        cls = ($urandom_range(0, 99) < 75) ? cls_prev : int'($urandom_range(1, 3));
        cls_prev = cls;
        step(1, cls == 1, cls == 2, cls == 3, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
